notch_seq: RTL and testbench
============================

Name: notch_seq

Overview:
- Sample sequencer and coefficient manager for the single adaptive notch filter instance (DATA_SIZE 24, COEF_SIZE 40).
- Accepts ADC samples and issues the filter's one-cycle sample trigger.
- Waits for filter_done, then presents the filtered result downstream.
- Owns the filter's `a` coefficient via a host-writable shadow register, committed only at sample boundaries so `a` never changes during a computation.
- Adds bypass, overrun detection, and a done-timeout with filter recovery.

Parameters:
- DATA_SIZE, 24, sample width.
- COEF_SIZE, 40, coefficient `a` width.
- TIMEOUT, 512, max clocks in WAIT before declaring filter hang (>=2).
- A_INIT, 40'd0, reset value of active and shadow coefficient.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- adc_data  in  DATA_SIZE  input sample
- adc_valid  in  1  one-cycle strobe, adc_data valid
- bypass  in  1  1: pass samples unfiltered
- coef_wr  in  1  host write strobe for shadow coefficient
- coef_data  in  COEF_SIZE  host coefficient value
- err_clr  in  1  clears sticky error flags
- filt_data_in  out  DATA_SIZE  to filter data_in, registered
- filt_sample  out  1  to filter sample input, one-cycle pulse
- filt_a  out  COEF_SIZE  to filter `a`, active coefficient
- filt_rst  out  1  one-cycle filter recovery reset after timeout
- filt_done  in  1  filter completion strobe
- filt_data_out  in  DATA_SIZE  filter result
- dout  out  DATA_SIZE  output sample, held until next update
- dout_valid  out  1  one-cycle strobe, dout updated
- busy  out  1  state != IDLE
- coef_pending  out  1  shadow written but not yet committed
- overrun  out  1  sticky: sample dropped
- timeout_err  out  1  sticky: filter did not finish in time

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, timer=0.
  - All 1-bit outputs 0; dout=0, filt_data_in=0.
  - filt_a=shadow=A_INIT, coef_pending=0.
  - Reset mid-operation aborts with no dout_valid.
- FSM states: IDLE, TRIG, WAIT, OUT.
- IDLE:
  - On adc_valid: filt_data_in<=adc_data.
  - If coef_pending: filt_a<=shadow, coef_pending<=0.
  - Then bypass=1 -> OUT with dout<=adc_data; bypass=0 -> TRIG.
- TRIG:
  - filt_sample=1 for exactly this cycle; timer<=0; -> WAIT.
- WAIT:
  - timer increments each cycle.
  - filt_done=1 -> dout<=filt_data_out, -> OUT.
  - Else if timer==TIMEOUT-1 -> timeout_err<=1, filt_rst=1 for one cycle, -> IDLE, no dout_valid, dout unchanged.
  - filt_done on the timeout cycle: done wins, no error.
- OUT:
  - dout_valid=1 for this cycle; -> IDLE.
- Latency:
  - Filtered: adc_valid at cycle 0, filt_sample at cycle 1; filt_done at cycle k gives dout_valid at k+1.
  - Bypass: adc_valid at cycle 0 gives dout_valid at cycle 1.
- Samples are accepted only in IDLE. adc_valid in TRIG/WAIT/OUT drops the sample, sets overrun, and leaves filt_data_in unchanged.
- filt_done outside WAIT is ignored.
- Coefficient shadow:
  - coef_wr: shadow<=coef_data, coef_pending<=1.
  - Repeated writes before commit: last write wins.
  - coef_wr in the same cycle as a commit: filt_a takes the old shadow; the new value is stored and coef_pending stays 1.
  - filt_a changes only on the IDLE accept cycle.
- bypass is sampled only on the IDLE accept cycle. Toggling it mid-sample has no effect on that sample.
- err_clr clears overrun and timeout_err. A set event in the same cycle wins over clear.
- filt_rst is never asserted during reset; the filter receives the system reset directly.
- No arithmetic on data. timer width is clog2(TIMEOUT); it saturates and never wraps.

Test Plan:
- Reset then idle: reset high for 3 cycles -> filt_a=A_INIT, dout=0, all strobes 0, busy=0.
- Filtered path: adc_data=24'h123456 strobe at t0; model asserts filt_done with filt_data_out=24'h0ABCDE at t0+6 -> filt_data_in=24'h123456, filt_sample pulse at t0+1 only, dout=24'h0ABCDE with dout_valid at t0+7, busy high t0+1..t0+7.
- Coefficient commit: coef_wr 40'h00_0000_1000, then 40'h00_0000_2000 while WAIT -> filt_a unchanged until the next adc_valid in IDLE, then 40'h2000; coef_pending 1 -> 0 on that cycle. Also exercise coef_wr coincident with commit.
- Overrun: second adc_valid at t0+3 during WAIT -> overrun=1, filt_data_in unchanged. err_clr clears it; err_clr coincident with a new overrun leaves it 1.
- Timeout (TIMEOUT=16): filt_done never asserted -> timeout_err=1 and filt_rst pulse 16 cycles after WAIT entry, return to IDLE, no dout_valid. Also check that done on the final cycle gives a normal output.
- Bypass and reset mid-op: bypass=1 with adc_data=24'hFFFFFF -> dout_valid next cycle, no filt_sample. Reset asserted in WAIT -> IDLE, no dout_valid, filt_a=A_INIT.

Source files
------------

// File: rtl/notch_seq.sv
// Purpose : sample sequencer and coefficient manager for one adaptive notch filter.
// Latency : filtered: trigger 1 clk after accept, dout_valid 1 clk after filt_done; bypass: dout_valid 1 clk after accept.
// Backpr. : none; samples arriving while busy are dropped and flagged in the sticky overrun bit.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   adc_data/adc_valid          input sample and its one-cycle strobe
//   bypass                      sampled on accept: route the sample straight to dout
//   coef_wr/coef_data           host write of the shadow `a` coefficient
//   err_clr                     clears the sticky overrun / timeout_err flags
//   filt_*                      filter interface (data, trigger, coefficient, recovery reset, done, result)
//   dout/dout_valid             output sample (held) and its update strobe
//   busy, coef_pending          status
//   overrun, timeout_err        sticky error flags
module notch_seq #(
    parameter int                   DATA_SIZE = 24,
    parameter int                   COEF_SIZE = 40,
    parameter int                   TIMEOUT   = 512,
    parameter logic [COEF_SIZE-1:0] A_INIT    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic                 bypass,
    input  logic                 coef_wr,
    input  logic [COEF_SIZE-1:0] coef_data,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] filt_data_in,
    output logic                 filt_sample,
    output logic [COEF_SIZE-1:0] filt_a,
    output logic                 filt_rst,
    input  logic                 filt_done,
    input  logic [DATA_SIZE-1:0] filt_data_out,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 coef_pending,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [TW-1:0]          timer_q,  timer_d;
    logic [DATA_SIZE-1:0]   fdi_q,    fdi_d;
    logic [COEF_SIZE-1:0]   fa_q,     fa_d;
    logic [COEF_SIZE-1:0]   shadow_q, shadow_d;
    logic                   pend_q,   pend_d;
    logic [DATA_SIZE-1:0]   dout_q,   dout_d;
    logic                   ovr_q,    ovr_d;
    logic                   tmo_q,    tmo_d;
    logic                   frst_q,   frst_d;
    logic                   set_ovr;
    logic                   set_tmo;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fdi_d    = fdi_q;
        fa_d     = fa_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        dout_d   = dout_q;
        frst_d   = 1'b0;
        set_ovr  = 1'b0;
        set_tmo  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (adc_valid) begin
                    fdi_d = adc_data;
                    // Commit point: `a` only moves here, never while the filter runs.
                    if (pend_q) begin
                        fa_d   = shadow_q;
                        pend_d = 1'b0;
                    end
                    if (bypass) begin
                        dout_d  = adc_data;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_TRIG;
                    end
                end
            end
            S_TRIG: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturate rather than wrap; the state always leaves at T_LAST anyway.
                if (timer_q != T_LAST) begin
                    timer_d = timer_q + TW'(1);
                end
                // done takes priority over the timeout on the last allowed cycle
                if (filt_done) begin
                    dout_d  = filt_data_out;
                    state_d = S_OUT;
                end else if (timer_q == T_LAST) begin
                    set_tmo = 1'b1;
                    frst_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adc_valid && (state_q != S_IDLE)) begin
            set_ovr = 1'b1;
        end

        // Evaluated after the commit so a coincident write survives as the next pending value.
        if (coef_wr) begin
            shadow_d = coef_data;
            pend_d   = 1'b1;
        end

        // Set events beat a simultaneous clear.
        ovr_d = set_ovr | (ovr_q & ~err_clr);
        tmo_d = set_tmo | (tmo_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            fdi_q    <= '0;
            fa_q     <= A_INIT;
            shadow_q <= A_INIT;
            pend_q   <= 1'b0;
            dout_q   <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
            frst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fdi_q    <= fdi_d;
            fa_q     <= fa_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            dout_q   <= dout_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            frst_q   <= frst_d;
        end
    end

    assign filt_data_in = fdi_q;
    assign filt_sample  = (state_q == S_TRIG);
    assign filt_a       = fa_q;
    assign filt_rst     = frst_q;
    assign dout         = dout_q;
    assign dout_valid   = (state_q == S_OUT);
    assign busy         = (state_q != S_IDLE);
    assign coef_pending = pend_q;
    assign overrun      = ovr_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_notch_seq.sv
module tb_notch_seq;

    localparam int          DW = 24;
    localparam int          CW = 40;
    localparam int          TO = 16;
    localparam logic [CW-1:0] AI = 40'h00_0000_0ABC;

    logic          clk;
    logic          reset;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          bypass;
    logic          coef_wr;
    logic [CW-1:0] coef_data;
    logic          err_clr;
    logic [DW-1:0] filt_data_in;
    logic          filt_sample;
    logic [CW-1:0] filt_a;
    logic          filt_rst;
    logic          filt_done;
    logic [DW-1:0] filt_data_out;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          coef_pending;
    logic          overrun;
    logic          timeout_err;

    notch_seq #(
        .DATA_SIZE(DW), .COEF_SIZE(CW), .TIMEOUT(TO), .A_INIT(AI)
    ) dut (
        .clk(clk), .reset(reset),
        .adc_data(adc_data), .adc_valid(adc_valid), .bypass(bypass),
        .coef_wr(coef_wr), .coef_data(coef_data), .err_clr(err_clr),
        .filt_data_in(filt_data_in), .filt_sample(filt_sample), .filt_a(filt_a),
        .filt_rst(filt_rst), .filt_done(filt_done), .filt_data_out(filt_data_out),
        .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .coef_pending(coef_pending), .overrun(overrun), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // A sample is described by its accept cycle, its route and (for the
    // filtered route) the cycle its done arrived; every output is derived
    // from these timestamps.
    longint        cyc = 0;
    bit            m_ok = 0;
    bit            m_act, m_byp, m_got, started;
    longint        t_acc, t_done, nxt;
    logic [DW-1:0] e_fdi, e_dout;
    logic [CW-1:0] e_fa, sh;
    bit            pend, ovr, tmo, e_rst, e_smp, e_dv, s_ovr, s_tmo;

    always begin
        @(posedge clk);
        if (reset) begin
            m_ok = 1; m_act = 0; m_byp = 0; m_got = 0;
            e_fdi = '0; e_dout = '0; e_fa = AI; sh = AI;
            pend = 0; ovr = 0; tmo = 0; e_rst = 0; e_smp = 0; e_dv = 0;
        end else if (m_ok) begin
            started = 0; s_ovr = 0; s_tmo = 0; e_rst = 0;
            if (!m_act && adc_valid) begin
                e_fdi = adc_data;
                if (pend) begin e_fa = sh; pend = 0; end
                t_acc = cyc; m_byp = bypass; m_got = 0; started = 1;
                if (bypass) e_dout = adc_data;
            end else if (m_act && adc_valid) begin
                s_ovr = 1;
            end
            if (m_act && !m_byp && !m_got && filt_done &&
                cyc >= t_acc + 2 && cyc <= t_acc + 1 + TO) begin
                m_got = 1; t_done = cyc; e_dout = filt_data_out;
            end
            if (m_act && !m_byp && !m_got && cyc == t_acc + 1 + TO) begin
                s_tmo = 1; e_rst = 1;
            end
            if (coef_wr) begin sh = coef_data; pend = 1; end
            if (s_ovr) ovr = 1; else if (err_clr) ovr = 0;
            if (s_tmo) tmo = 1; else if (err_clr) tmo = 0;
            nxt = cyc + 1;
            if (m_act || started)
                m_act = m_byp ? (nxt <= t_acc + 1)
                              : (m_got ? (nxt <= t_done + 1) : (nxt <= t_acc + 1 + TO));
            e_smp = m_act && !m_byp && (nxt == t_acc + 1);
            e_dv  = m_act && (m_byp ? (nxt == t_acc + 1) : (m_got && nxt == t_done + 1));
        end
        cyc++;
        #1;
        if (m_ok) begin
            chk("m_fdi",  filt_data_in, e_fdi);
            chk("m_smp",  filt_sample,  e_smp);
            chk("m_fa",   filt_a,       e_fa);
            chk("m_rst",  filt_rst,     e_rst);
            chk("m_dout", dout,         e_dout);
            chk("m_dv",   dout_valid,   e_dv);
            chk("m_busy", busy,         m_act);
            chk("m_pend", coef_pending, pend);
            chk("m_ovr",  overrun,      ovr);
            chk("m_tmo",  timeout_err,  tmo);
        end
    end

    // ---------------- directed stimulus ----------------
    // After step() the bench sits at a falling edge: outputs of the current
    // cycle are stable and inputs set now are sampled at the next rising edge.
    task automatic step();
        @(negedge clk);
        adc_valid = 0; coef_wr = 0; err_clr = 0; filt_done = 0;
    endtask

    initial begin
        reset = 1; adc_data = '0; adc_valid = 0; bypass = 0; coef_wr = 0;
        coef_data = '0; err_clr = 0; filt_done = 0; filt_data_out = '0;
        repeat (3) step();
        chk("rst_fa", filt_a, AI);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {filt_sample, dout_valid, filt_rst, overrun, timeout_err, coef_pending}, 0);
        reset = 0;

        // filtered sample, overrun and shadow writes during WAIT
        step(); adc_valid = 1; adc_data = 24'h123456; bypass = 0;            // c0
        step(); chk("f_smp1", filt_sample, 1); chk("f_fdi", filt_data_in, 24'h123456);
                chk("f_busy1", busy, 1);                                      // c1
        step(); chk("f_smp2", filt_sample, 0);                                // c2
        step(); adc_valid = 1; adc_data = 24'h654321;
                coef_wr = 1; coef_data = 40'h00_0000_1000;                    // c3
        step(); coef_wr = 1; coef_data = 40'h00_0000_2000;
                chk("ovr_set", overrun, 1); chk("ovr_fdi", filt_data_in, 24'h123456);
                chk("cw_pend", coef_pending, 1); chk("cw_fa", filt_a, AI);    // c4
        step(); chk("cw_fa2", filt_a, AI);                                    // c5
        step(); filt_done = 1; filt_data_out = 24'h0ABCDE;                    // c6
                chk("f_dv6", dout_valid, 0);
        step(); chk("f_dv7", dout_valid, 1); chk("f_dout", dout, 24'h0ABCDE);
                chk("f_busy7", busy, 1);                                      // c7
        step(); chk("f_idle", busy, 0); err_clr = 1;                          // c8
        step(); chk("ovr_clr", overrun, 0);                                   // c9

        // bypass accept commits 0x2000 while a coincident write stays pending
        step(); adc_valid = 1; adc_data = 24'h000055; bypass = 1;
                coef_wr = 1; coef_data = 40'h00_0000_3000;
        step(); chk("b_dv", dout_valid, 1); chk("b_dout", dout, 24'h000055);
                chk("b_smp", filt_sample, 0); chk("cm_fa", filt_a, 40'h00_0000_2000);
                chk("cm_pend", coef_pending, 1); bypass = 0;
        step(); adc_valid = 1; adc_data = 24'hFFFFFF; bypass = 1;
        step(); chk("b2_dv", dout_valid, 1); chk("b2_dout", dout, 24'hFFFFFF);
                chk("cm2_fa", filt_a, 40'h00_0000_3000); chk("cm2_pend", coef_pending, 0);

        // timeout, with overrun racing err_clr and a mid-sample bypass toggle
        step(); bypass = 0; adc_valid = 1; adc_data = 24'h0000AA;            // c14
        step(); adc_valid = 1; err_clr = 1;                                   // c15
        step(); chk("ovr_win", overrun, 1); bypass = 1;                       // c16
        step(); bypass = 0;                                                   // c17
        repeat (13) step();                                                   // c30
        step(); chk("to_pre_rst", filt_rst, 0); chk("to_pre_busy", busy, 1);  // c31
        step(); chk("to_rst", filt_rst, 1); chk("to_err", timeout_err, 1);
                chk("to_busy", busy, 0); chk("to_dv", dout_valid, 0);
                chk("to_dout", dout, 24'hFFFFFF);                             // c32
        step(); chk("to_rst_off", filt_rst, 0); err_clr = 1;                  // c33

        // done on the last allowed WAIT cycle
        step(); chk("to_clr", timeout_err, 0); adc_valid = 1; adc_data = 24'h000111; // c34
        repeat (16) step();                                                   // c50
        step(); chk("late_busy", busy, 1); filt_done = 1; filt_data_out = 24'h0F0F0F; // c51
        step(); chk("late_dv", dout_valid, 1); chk("late_dout", dout, 24'h0F0F0F);
                chk("late_err", timeout_err, 0); chk("late_rst", filt_rst, 0);

        // reset in the middle of a sample
        step(); coef_wr = 1; coef_data = 40'h00_0000_4000;
        step(); adc_valid = 1; adc_data = 24'h000222;
        step(); chk("mr_fa", filt_a, 40'h00_0000_4000);
        step(); reset = 1;
        step(); chk("mr_busy", busy, 0); chk("mr_fa0", filt_a, AI); chk("mr_dv", dout_valid, 0);
                chk("mr_dout", dout, 0); reset = 0;
        step(); filt_done = 1; filt_data_out = 24'h000123;
        step(); chk("ign_dv", dout_valid, 0); chk("ign_dout", dout, 0);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
